// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor family.
// Entries are sized for the widest supported tag/counter; unused upper bits stay constant.
package bp_pkg;

    localparam int CTR_MAX_W = 8;
    localparam int TAG_MAX_W = 16;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        ctr_t                 ctr;
    } pht_entry_t;

    // Lowest counter value that predicts taken.
    function automatic ctr_t ctr_weak_taken(input int unsigned ctr_w);
        return ctr_t'(1) << (ctr_w - 1);
    endfunction

    function automatic ctr_t ctr_weak_not_taken(input int unsigned ctr_w);
        return ctr_weak_taken(ctr_w) - ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_max(input int unsigned ctr_w);
        return ctr_t'((1 << ctr_w) - 1);
    endfunction

    // Saturating up/down step; never wraps at either end.
    function automatic ctr_t sat_update(input ctr_t ctr, input logic outcome,
                                        input int unsigned ctr_w);
        if (outcome) begin
            return (ctr >= ctr_max(ctr_w)) ? ctr_max(ctr_w) : ctr + ctr_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Tagged pattern history table: one combinational read port, one synchronous
// write port that allocates on tag miss and saturates on hit.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 4,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic               rd_taken,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_outcome
);

    localparam int DEPTH = 1 << INDEX_W;

    pht_entry_t entries [DEPTH];
    pht_entry_t rd_entry;
    pht_entry_t wr_entry;
    logic       wr_hit;
    logic       unused_ctr;

    assign rd_entry = entries[rd_index];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(rd_tag));
    assign rd_taken = rd_hit && rd_entry.ctr[CTR_W-1];

    assign unused_ctr = ^rd_entry.ctr;

    assign wr_entry = entries[wr_index];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == TAG_MAX_W'(wr_tag));

    // Reads see the pre-write entry: there is deliberately no write-to-read bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].tag   <= '0;
                entries[i].ctr   <= ctr_weak_not_taken(CTR_W);
            end
        end else if (wr_en) begin
            if (wr_hit) begin
                entries[wr_index].ctr <= sat_update(wr_entry.ctr, wr_outcome, CTR_W);
            end else begin
                entries[wr_index].valid <= 1'b1;
                entries[wr_index].tag   <= TAG_MAX_W'(wr_tag);
                entries[wr_index].ctr   <= wr_outcome ? ctr_weak_taken(CTR_W)
                                                      : ctr_weak_not_taken(CTR_W);
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Tagged gshare predictor: PC/GHR hash, speculative GHR with mispredict restore,
// and a saturating mispredict counter around the tagged pattern table.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INDEX_W = 6,
    parameter int HIST_W  = 6,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_bits_read,
    input  logic               predict_valid,
    output logic               prediction,
    output logic               pred_hit,
    output logic [INDEX_W-1:0] pred_index,
    output logic [HIST_W-1:0]  ghr_snapshot,
    input  logic               write_enabled,
    input  logic [PC_W-1:0]    pc_bits_write,
    input  logic [INDEX_W-1:0] write_index,
    input  logic               outcome,
    input  logic               mispredict,
    input  logic [HIST_W-1:0]  ghr_restore,
    output logic [15:0]        mispredict_count
);

    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_next;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  wr_tag;
    logic              flush;
    logic              unused_pc;

    assign flush        = write_enabled && mispredict;
    assign pred_index   = pc_bits_read[INDEX_W-1:0] ^ INDEX_W'(ghr);
    assign rd_tag       = pc_bits_read[INDEX_W+TAG_W-1:INDEX_W];
    assign wr_tag       = pc_bits_write[INDEX_W+TAG_W-1:INDEX_W];
    assign ghr_snapshot = ghr;
    assign unused_pc    = ^{pc_bits_read, pc_bits_write};

    gshare_pht #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .CTR_W   (CTR_W)
    ) u_pht (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (pred_index),
        .rd_tag     (rd_tag),
        .rd_hit     (pred_hit),
        .rd_taken   (prediction),
        .wr_en      (write_enabled),
        .wr_index   (write_index),
        .wr_tag     (wr_tag),
        .wr_outcome (outcome)
    );

    // A resolved mispredict flushes the younger fetch, so its shift is dropped.
    if (HIST_W == 1) begin : g_hist1
        logic unused_restore;
        assign unused_restore = ^ghr_restore;
        always_comb begin
            ghr_next = ghr;
            if (flush) begin
                ghr_next = outcome;
            end else if (predict_valid) begin
                ghr_next = prediction;
            end
        end
    end else begin : g_histn
        always_comb begin
            ghr_next = ghr;
            if (flush) begin
                ghr_next = {ghr_restore[HIST_W-2:0], outcome};
            end else if (predict_valid) begin
                ghr_next = {ghr[HIST_W-2:0], prediction};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr              <= '0;
            mispredict_count <= '0;
        end else begin
            ghr <= ghr_next;
            if (flush && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios plus random traffic, all
// checked against a table/integer reference model of the predictor.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_bits_read;
    logic        predict_valid;
    logic        prediction;
    logic        pred_hit;
    logic [5:0]  pred_index;
    logic [5:0]  ghr_snapshot;
    logic        write_enabled;
    logic [15:0] pc_bits_write;
    logic [5:0]  write_index;
    logic        outcome;
    logic        mispredict;
    logic [5:0]  ghr_restore;
    logic [15:0] mispredict_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_valid [64];
    int m_tag   [64];
    int m_ctr   [64];
    int m_ghr;
    int m_count;

    gshare_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .pc_bits_read     (pc_bits_read),
        .predict_valid    (predict_valid),
        .prediction       (prediction),
        .pred_hit         (pred_hit),
        .pred_index       (pred_index),
        .ghr_snapshot     (ghr_snapshot),
        .write_enabled    (write_enabled),
        .pc_bits_write    (pc_bits_write),
        .write_index      (write_index),
        .outcome          (outcome),
        .mispredict       (mispredict),
        .ghr_restore      (ghr_restore),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_ghr   = 0;
        m_count = 0;
    endtask

    function automatic int m_idx(input int pc);
        return (pc % 64) ^ m_ghr;
    endfunction

    function automatic bit m_hit(input int pc);
        int i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == (pc / 64) % 16);
    endfunction

    function automatic bit m_pred(input int pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    task automatic clear_inputs();
        predict_valid = 0;
        write_enabled = 0;
        mispredict    = 0;
        outcome       = 0;
        pc_bits_write = 0;
        write_index   = 0;
        ghr_restore   = 0;
    endtask

    // Inputs are already driven; compare outputs, cross the edge, advance the model.
    task automatic step(input string name);
        bit p;
        int ti;
        #2;
        p = m_pred(int'(pc_bits_read));
        check({name, ".pred_index"}, 32'(pred_index), 32'(m_idx(int'(pc_bits_read))));
        check({name, ".pred_hit"}, 32'(pred_hit), 32'(m_hit(int'(pc_bits_read))));
        check({name, ".prediction"}, 32'(prediction), 32'(p));
        check({name, ".ghr"}, 32'(ghr_snapshot), 32'(m_ghr));
        check({name, ".mcount"}, 32'(mispredict_count), 32'(m_count));
        @(posedge clk);
        if (write_enabled) begin
            ti = int'(write_index);
            if (m_valid[ti] && m_tag[ti] == (int'(pc_bits_write) / 64) % 16) begin
                if (outcome) m_ctr[ti] = (m_ctr[ti] == 3) ? 3 : m_ctr[ti] + 1;
                else         m_ctr[ti] = (m_ctr[ti] == 0) ? 0 : m_ctr[ti] - 1;
            end else begin
                m_valid[ti] = 1'b1;
                m_tag[ti]   = (int'(pc_bits_write) / 64) % 16;
                m_ctr[ti]   = outcome ? 2 : 1;
            end
        end
        if (write_enabled && mispredict) begin
            m_ghr   = (int'(ghr_restore) * 2 + int'(outcome)) % 64;
            m_count = (m_count == 65535) ? 65535 : m_count + 1;
        end else if (predict_valid) begin
            m_ghr = (m_ghr * 2 + int'(p)) % 64;
        end
        #1;
    endtask

    task automatic write_op(input int pc, input int idx, input bit taken);
        write_enabled = 1;
        pc_bits_write = 16'(pc);
        write_index   = 6'(idx);
        outcome       = taken;
        step("write");
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        pc_bits_read = 16'h0040;
        reset = 1;
        model_reset();
        #1;
        check("reset.prediction", 32'(prediction), 32'd0);
        check("reset.pred_hit", 32'(pred_hit), 32'd0);
        check("reset.ghr", 32'(ghr_snapshot), 32'd0);
        check("reset.mcount", 32'(mispredict_count), 32'd0);
        #11 reset = 0;
        @(posedge clk);
        #1;

        // Allocate idx 0 taken, then read it back
        write_op(16'h0040, 0, 1);
        #2;
        check("alloc.pred_index", 32'(pred_index), 32'd0);
        check("alloc.pred_hit", 32'(pred_hit), 32'd1);
        check("alloc.prediction", 32'(prediction), 32'd1);
        #0;
        step("alloc");

        // Saturation up, then down
        for (int i = 0; i < 3; i++) write_op(16'h0040, 0, 1);
        for (int i = 0; i < 2; i++) write_op(16'h0040, 0, 0);
        #2 check("sat.two_nt_pred", 32'(prediction), 32'd0);
        check("sat.two_nt_hit", 32'(pred_hit), 32'd1);
        for (int i = 0; i < 3; i++) write_op(16'h0040, 0, 0);
        write_op(16'h0040, 0, 1);
        #2 check("sat.floor_then_up_pred", 32'(prediction), 32'd0);
        step("sat");

        // Tag conflict at idx 0
        pc_bits_read = 16'h0080;
        #2 check("conflict.miss_hit", 32'(pred_hit), 32'd0);
        check("conflict.miss_pred", 32'(prediction), 32'd0);
        step("conflict_pre");
        write_op(16'h0080, 0, 1);
        pc_bits_read = 16'h0040;
        #2 check("conflict.old_miss", 32'(pred_hit), 32'd0);
        step("conflict_old");

        // GHR speculation with taken entries at idx 0, 1, 3 (tag 2)
        write_op(16'h0080, 1, 1);
        write_op(16'h0080, 3, 1);
        pc_bits_read  = 16'h0080;
        predict_valid = 1;
        for (int i = 0; i < 3; i++) step("spec");
        #2 check("spec.ghr", 32'(ghr_snapshot), 32'h07);
        write_enabled = 1;
        mispredict    = 1;
        ghr_restore   = 6'b000001;
        outcome       = 0;
        write_index   = 6'd5;
        pc_bits_write = 16'h0000;
        step("restore");
        clear_inputs();
        #2 check("restore.ghr", 32'(ghr_snapshot), 32'h02);
        check("restore.mcount", 32'(mispredict_count), 32'd1);

        // Hash and same-cycle read/write at idx 6
        write_enabled = 1;
        mispredict    = 1;
        ghr_restore   = 6'b000001;
        outcome       = 1;
        write_index   = 6'd9;
        step("set_ghr3");
        clear_inputs();
        pc_bits_read  = 16'h0005;
        write_enabled = 1;
        pc_bits_write = 16'h0005;
        write_index   = 6'd6;
        outcome       = 1;
        #2 check("hash.pred_index", 32'(pred_index), 32'h06);
        check("bypass.old_hit", 32'(pred_hit), 32'd0);
        step("bypass");
        clear_inputs();
        #2 check("bypass.new_hit", 32'(pred_hit), 32'd1);
        check("bypass.new_pred", 32'(prediction), 32'd1);
        step("bypass_next");

        // Random traffic; narrow PC range keeps tag hits frequent
        for (int n = 0; n < 600; n++) begin
            pc_bits_read  = 16'($urandom_range(0, 255));
            predict_valid = 1'($urandom_range(0, 1));
            write_enabled = ($urandom_range(0, 2) != 0);
            pc_bits_write = 16'($urandom_range(0, 255));
            write_index   = 6'($urandom);
            outcome       = 1'($urandom);
            mispredict    = ($urandom_range(0, 3) == 0);
            ghr_restore   = 6'($urandom);
            step("rand");
        end

        // Asynchronous reset between edges
        #2 reset = 1;
        #1;
        model_reset();
        check("areset.prediction", 32'(prediction), 32'd0);
        check("areset.pred_hit", 32'(pred_hit), 32'd0);
        check("areset.ghr", 32'(ghr_snapshot), 32'd0);
        check("areset.mcount", 32'(mispredict_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        for (int n = 0; n < 64; n++) begin
            pc_bits_read = 16'($urandom_range(0, 255));
            step("post_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
